// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared widths, opcodes and pipeline register types for the decode stage
package id_stage_pkg;
  localparam int WORD     = 32;
  localparam int REG_ADDR = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef struct packed {
    logic            valid;
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic                valid;
    logic [WORD-1:0]     pc;
    logic [WORD-1:0]     rs_data;
    logic [WORD-1:0]     rt_data;
    logic [WORD-1:0]     imm;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_ADDR-1:0] rs;
    logic [REG_ADDR-1:0] rt;
    logic [REG_ADDR-1:0] rd;
    logic [REG_ADDR-1:0] shamt;
    logic                link;
  } id_ex_t;

  function automatic logic [WORD-1:0] sext16(input logic [15:0] v);
    return {{(WORD-16){v[15]}}, v};
  endfunction
endpackage

// File: rtl/id_stage_reg_file.sv
// rtl/id_stage_reg_file.sv - 32x32 register file, combinational reads with write-first bypass
module reg_file
  import id_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REG_ADDR-1:0] waddr,
  input  logic [WORD-1:0]     wdata,
  input  logic [REG_ADDR-1:0] raddr1,
  input  logic [REG_ADDR-1:0] raddr2,
  output logic [WORD-1:0]     rdata1,
  output logic [WORD-1:0]     rdata2
);
  logic [WORD-1:0] regs_q [32];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // A write landing this cycle is visible to the reader in the same cycle.
  assign rdata1 = (raddr1 == '0) ? '0 : (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, register file, hazards, branch/jump resolution
module id_stage
  import id_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD-1:0]     if_pc,
  input  logic [WORD-1:0]     if_instruction,
  input  logic                wb_reg_write,
  input  logic [REG_ADDR-1:0] wb_write_reg,
  input  logic [WORD-1:0]     wb_write_data,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [REG_ADDR-1:0] ex_write_reg,
  input  logic                mem_reg_write,
  input  logic                mem_mem_read,
  input  logic [REG_ADDR-1:0] mem_write_reg,
  input  logic [WORD-1:0]     mem_alu_result,
  output logic                stall,
  output logic                branch_taken,
  output logic                jump_taken,
  output logic [WORD-1:0]     branch_offset,
  output logic [WORD-1:0]     new_addr,
  output logic                id_ex_valid,
  output logic [WORD-1:0]     id_ex_pc,
  output logic [WORD-1:0]     id_ex_rs_data,
  output logic [WORD-1:0]     id_ex_rt_data,
  output logic [WORD-1:0]     id_ex_imm,
  output logic [5:0]          id_ex_opcode,
  output logic [5:0]          id_ex_funct,
  output logic [REG_ADDR-1:0] id_ex_rs,
  output logic [REG_ADDR-1:0] id_ex_rt,
  output logic [REG_ADDR-1:0] id_ex_rd,
  output logic [REG_ADDR-1:0] id_ex_shamt,
  output logic                id_ex_link
);
  if_id_t ifid_q, ifid_d;
  id_ex_t idex_q, idex_d;

  logic [5:0]          opcode, funct;
  logic [REG_ADDR-1:0] rs, rt, rd, shamt;
  logic [WORD-1:0]     rf_rs, rf_rt, op_a, op_b, imm;
  logic is_beq, is_bne, is_br, is_j, is_jal, is_jr, uses_rs, uses_rt;
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_use, br_pending, flush;

  assign opcode = ifid_q.instr[31:26];
  assign rs     = ifid_q.instr[25:21];
  assign rt     = ifid_q.instr[20:16];
  assign rd     = ifid_q.instr[15:11];
  assign shamt  = ifid_q.instr[10:6];
  assign funct  = ifid_q.instr[5:0];

  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_br   = is_beq | is_bne;
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jr   = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  // rt is a source for R-type, branches and stores (opcodes 101xxx); a destination otherwise.
  assign uses_rs = ~(is_j | is_jal);
  assign uses_rt = (opcode == OP_RTYPE) | is_br | (opcode[5:3] == 3'b101);

  reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rs),
    .rdata2 (rf_rt)
  );

  assign ex_rs_hit  = (rs != '0) && (ex_write_reg == rs);
  assign ex_rt_hit  = (rt != '0) && (ex_write_reg == rt);
  assign mem_rs_hit = (rs != '0) && (mem_write_reg == rs);
  assign mem_rt_hit = (rt != '0) && (mem_write_reg == rt);

  // An ALU result sitting in MEM is usable now; a load in MEM is not.
  assign op_a = (rs == '0) ? '0 : (mem_reg_write && !mem_mem_read && mem_rs_hit) ? mem_alu_result : rf_rs;
  assign op_b = (rt == '0) ? '0 : (mem_reg_write && !mem_mem_read && mem_rt_hit) ? mem_alu_result : rf_rt;

  assign load_use   = ex_mem_read & ((uses_rs & ex_rs_hit) | (uses_rt & ex_rt_hit));
  assign br_pending = ((is_br | is_jr) & ((ex_reg_write & ex_rs_hit) | (mem_mem_read & mem_rs_hit)))
                    | (is_br & ((ex_reg_write & ex_rt_hit) | (mem_mem_read & mem_rt_hit)));

  assign stall        = ~rst & ifid_q.valid & (load_use | br_pending);
  assign branch_taken = ~rst & ifid_q.valid & ~stall
                      & ((is_beq & (op_a == op_b)) | (is_bne & (op_a != op_b)));
  assign jump_taken   = ~rst & ifid_q.valid & ~stall & (is_j | is_jal | is_jr);
  assign flush        = branch_taken | jump_taken;

  assign branch_offset = sext16(ifid_q.instr[15:0]);
  assign new_addr      = is_jr ? (op_a >> 2) : {6'b0, ifid_q.instr[25:0]};
  assign imm           = (opcode[5:2] == 4'b0011) ? {16'b0, ifid_q.instr[15:0]} : sext16(ifid_q.instr[15:0]);

  always_comb begin
    ifid_d = ifid_q;
    if (!stall) begin
      if (flush) ifid_d = '0;
      else       ifid_d = '{valid: 1'b1, pc: if_pc, instr: if_instruction};
    end
  end

  always_comb begin
    idex_d = '0;
    if (ifid_q.valid && !stall) begin
      idex_d = '{valid: 1'b1, pc: ifid_q.pc, rs_data: op_a, rt_data: op_b, imm: imm,
                 opcode: opcode, funct: funct, rs: rs, rt: rt, rd: rd, shamt: shamt,
                 link: is_jal};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign id_ex_valid   = idex_q.valid;
  assign id_ex_pc      = idex_q.pc;
  assign id_ex_rs_data = idex_q.rs_data;
  assign id_ex_rt_data = idex_q.rt_data;
  assign id_ex_imm     = idex_q.imm;
  assign id_ex_opcode  = idex_q.opcode;
  assign id_ex_funct   = idex_q.funct;
  assign id_ex_rs      = idex_q.rs;
  assign id_ex_rt      = idex_q.rt;
  assign id_ex_rd      = idex_q.rd;
  assign id_ex_shamt   = idex_q.shamt;
  assign id_ex_link    = idex_q.link;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for the decode stage
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instruction;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_write_reg;
  logic        mem_reg_write, mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result;
  logic        stall, branch_taken, jump_taken;
  logic [31:0] branch_offset, new_addr;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [5:0]  id_ex_opcode, id_ex_funct;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
  logic        id_ex_link;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .mem_alu_result(mem_alu_result), .stall(stall), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .branch_offset(branch_offset), .new_addr(new_addr),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_opcode(id_ex_opcode),
    .id_ex_funct(id_ex_funct), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_shamt(id_ex_shamt), .id_ex_link(id_ex_link)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];

  typedef struct packed {
    logic [31:0] ins;
    logic        exrw, exmr;
    logic [4:0]  exr;
    logic        memrw, memmr;
    logic [4:0]  memr;
    logic [31:0] alu;
    logic        st, br, jp;
    logic [31:0] na;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_haz;
    ex_reg_write = 0; ex_mem_read = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_write_reg = 0; mem_alu_result = 0;
    wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
  endtask

  // A NOP first absorbs any flush left by the previous instruction, then ins enters IF/ID.
  task automatic load(input logic [31:0] pc, input logic [31:0] ins);
    clr_haz();
    if_pc = pc - 4; if_instruction = 32'h0;
    tick();
    if_pc = pc; if_instruction = ins;
    tick();
    if_pc = pc + 4; if_instruction = 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    clr_haz();
    if_instruction = 32'h0;
    wb_reg_write = 1; wb_write_reg = r; wb_write_data = d;
    tick();
    if (r != 0) rf[r] = d;
    wb_reg_write = 0;
  endtask

  task automatic do_reset;
    clr_haz();
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 32; i++) rf[i] = 0;
  endtask

  // Value the decode stage should see for register r right now.
  function automatic logic [31:0] mval(input logic [4:0] r);
    if (r == 0) return 0;
    if (mem_reg_write && !mem_mem_read && mem_write_reg == r) return mem_alu_result;
    if (wb_reg_write && wb_write_reg == r) return wb_write_data;
    return rf[r];
  endfunction

  function automatic bit not_ready(input logic [4:0] r);
    return r != 0 && ((ex_reg_write && ex_write_reg == r) || (mem_mem_read && mem_write_reg == r));
  endfunction

  task automatic check_all(input logic [31:0] pc, input logic [31:0] ins);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit beq, bne, jj, jal, jr, urs, urt, st, br, jp;
    logic [31:0] a, b, imm;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    beq = op == 6'd4; bne = op == 6'd5; jj = op == 6'd2; jal = op == 6'd3;
    jr = op == 6'd0 && fn == 6'd8;
    urs = !(jj || jal);
    urt = op == 6'd0 || beq || bne || op == 6'h28 || op == 6'h29 || op == 6'h2B;
    st = (ex_mem_read && ((urs && rs != 0 && ex_write_reg == rs) || (urt && rt != 0 && ex_write_reg == rt)))
       || ((beq || bne) && (not_ready(rs) || not_ready(rt))) || (jr && not_ready(rs));
    a = mval(rs); b = mval(rt);
    br = !st && ((beq && a == b) || (bne && a != b));
    jp = !st && (jj || jal || jr);
    imm = (op >= 6'h0C && op <= 6'h0F) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    #1;
    chk("rnd_stall", stall, st);
    chk("rnd_branch", branch_taken, br);
    chk("rnd_jump", jump_taken, jp);
    chk("rnd_offset", branch_offset, {{16{ins[15]}}, ins[15:0]});
    if (jp) chk("rnd_new_addr", new_addr, jr ? a >> 2 : {6'b0, ins[25:0]});
    tick();
    if (wb_reg_write && wb_write_reg != 0) rf[wb_write_reg] = wb_write_data;
    if (st) begin
      chk("rnd_bubble_valid", id_ex_valid, 0);
      chk("rnd_bubble_pc", id_ex_pc, 0);
      chk("rnd_bubble_imm", id_ex_imm, 0);
    end else begin
      chk("rnd_valid", id_ex_valid, 1);
      chk("rnd_pc", id_ex_pc, pc);
      chk("rnd_rs_data", id_ex_rs_data, a);
      chk("rnd_rt_data", id_ex_rt_data, b);
      chk("rnd_imm", id_ex_imm, imm);
      chk("rnd_fields", {id_ex_opcode, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt, id_ex_funct}, ins);
      chk("rnd_link", id_ex_link, jal);
    end
  endtask

  initial begin
    logic [31:0] ins, pc;
    logic [4:0]  r1, r2, r3;
    logic [15:0] im;
    rst = 1; if_pc = 0; if_instruction = 0;
    clr_haz();

    // Reset: bubbles, quiet control outputs, register file cleared.
    do_reset();
    wb_write(5'd1, 32'h55);
    do_reset();
    #1;
    chk("reset_valid", id_ex_valid, 0);
    chk("reset_pc", id_ex_pc, 0);
    chk("reset_stall", stall, 0);
    chk("reset_branch", branch_taken, 0);
    chk("reset_jump", jump_taken, 0);
    load(32'h10, 32'h00203820);
    tick();
    chk("reset_rf_cleared", id_ex_rs_data, 0);

    // addi $1,$0,5
    load(32'h20, 32'h20010005);
    #1 chk("addi_stall", stall, 0);
    tick();
    chk("addi_valid", id_ex_valid, 1);
    chk("addi_imm", id_ex_imm, 5);
    chk("addi_rt", id_ex_rt, 1);

    // Table of single-cycle hazard and control vectors.
    vecs[0]  = '{32'h00421820, 1, 1, 5'd2,  0, 0, 5'd0, 32'd0, 1, 0, 0, 32'h0};
    vecs[1]  = '{32'h00421820, 1, 1, 5'd0,  0, 0, 5'd0, 32'd0, 0, 0, 0, 32'h0};
    vecs[2]  = '{32'hAC220000, 1, 1, 5'd2,  0, 0, 5'd0, 32'd0, 1, 0, 0, 32'h0};
    vecs[3]  = '{32'h8C220000, 1, 1, 5'd2,  0, 0, 5'd0, 32'd0, 0, 0, 0, 32'h0};
    vecs[4]  = '{32'h1084FFFD, 1, 0, 5'd4,  0, 0, 5'd0, 32'd0, 1, 0, 0, 32'h0};
    vecs[5]  = '{32'h1084FFFD, 0, 0, 5'd0,  1, 1, 5'd4, 32'd0, 1, 0, 0, 32'h0};
    vecs[6]  = '{32'h1084FFFD, 0, 0, 5'd0,  1, 0, 5'd4, 32'd3, 0, 1, 0, 32'h0};
    vecs[7]  = '{32'h14A00002, 0, 0, 5'd0,  1, 0, 5'd5, 32'd0, 0, 0, 0, 32'h0};
    vecs[8]  = '{32'h14A00002, 0, 0, 5'd0,  1, 0, 5'd5, 32'd9, 0, 1, 0, 32'h0};
    vecs[9]  = '{32'h08000100, 0, 0, 5'd0,  0, 0, 5'd0, 32'd0, 0, 0, 1, 32'h00000100};
    vecs[10] = '{32'h0FFFFFFF, 0, 0, 5'd0,  0, 0, 5'd0, 32'd0, 0, 0, 1, 32'h03FFFFFF};
    vecs[11] = '{32'h08A00000, 1, 1, 5'd5,  0, 0, 5'd0, 32'd0, 0, 0, 1, 32'h00A00000};
    vecs[12] = '{32'h03E00008, 1, 0, 5'd31, 0, 0, 5'd0, 32'd0, 1, 0, 0, 32'h0};
    vecs[13] = '{32'h14A00002, 0, 0, 5'd0,  1, 1, 5'd5, 32'd9, 1, 0, 0, 32'h0};
    for (int i = 0; i < 14; i++) begin
      load(32'h1000 + 32'(i) * 16, vecs[i].ins);
      ex_reg_write = vecs[i].exrw; ex_mem_read = vecs[i].exmr; ex_write_reg = vecs[i].exr;
      mem_reg_write = vecs[i].memrw; mem_mem_read = vecs[i].memmr; mem_write_reg = vecs[i].memr;
      mem_alu_result = vecs[i].alu;
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].st);
      chk($sformatf("vec%0d_branch", i), branch_taken, vecs[i].br);
      chk($sformatf("vec%0d_jump", i), jump_taken, vecs[i].jp);
      if (vecs[i].jp) chk($sformatf("vec%0d_new_addr", i), new_addr, vecs[i].na);
      tick();
      chk($sformatf("vec%0d_id_ex_valid", i), id_ex_valid, !vecs[i].st);
    end

    // Load-use: one stall, IF/ID held, then the add issues.
    load(32'h200, 32'h00421820);
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 2;
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", id_ex_valid, 0);
    clr_haz();
    #1 chk("lu_release", stall, 0);
    tick();
    chk("lu_issue_valid", id_ex_valid, 1);
    chk("lu_issue_rd", id_ex_rd, 3);
    chk("lu_issue_pc", id_ex_pc, 32'h200);

    // Taken beq squashes the fall-through instruction.
    wb_write(5'd4, 32'd7);
    load(32'h300, 32'h1084FFFD);
    #1;
    chk("beq_taken", branch_taken, 1);
    chk("beq_offset", branch_offset, 32'hFFFFFFFD);
    if_instruction = 32'h20010005; if_pc = 32'h304;
    tick();
    chk("beq_in_ex", id_ex_opcode, 6'd4);
    chk("beq_ifid_bubble", branch_taken, 0);
    if_instruction = 32'h0;
    tick();
    chk("beq_squashed", id_ex_valid, 0);

    // bne forwarded from an ALU result in MEM.
    wb_write(5'd5, 32'd0);
    load(32'h400, 32'h14A00002);
    mem_reg_write = 1; mem_write_reg = 5; mem_alu_result = 9;
    #1;
    chk("bne_fwd_taken", branch_taken, 1);
    chk("bne_fwd_stall", stall, 0);

    // jr $31
    wb_write(5'd31, 32'h40);
    load(32'h500, 32'h03E00008);
    #1;
    chk("jr_taken", jump_taken, 1);
    chk("jr_new_addr", new_addr, 32'h10);

    // WB write-first bypass into the decoded operand.
    load(32'h600, 32'h00C03820);
    wb_reg_write = 1; wb_write_reg = 6; wb_write_data = 32'hAA;
    tick();
    rf[6] = 32'hAA;
    chk("wb_bypass", id_ex_rs_data, 32'hAA);

    // Reset during a stall discards the held instruction.
    load(32'h700, 32'h00421820);
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 2;
    #1 chk("rst_pre_stall", stall, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_mid_valid", id_ex_valid, 0);
    chk("rst_mid_pc", id_ex_pc, 0);
    chk("rst_mid_rd", id_ex_rd, 0);
    chk("rst_mid_stall", stall, 0);
    for (int i = 0; i < 32; i++) rf[i] = 0;

    // Randomized instructions and hazard inputs against the reference model.
    for (int r = 1; r < 32; r++) wb_write(5'(r), 32'($urandom_range(0, 3)));
    for (int n = 0; n < 200; n++) begin
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); r3 = 5'($urandom_range(0, 7));
      im = 16'($urandom);
      case ($urandom_range(0, 10))
        0:  ins = {6'h00, r1, r2, r3, 5'($urandom), 6'h20};
        1:  ins = {6'h08, r1, r2, im};
        2:  ins = {6'h0C, r1, r2, im};
        3:  ins = {6'h0D, r1, r2, im};
        4:  ins = {6'h0F, 5'd0, r2, im};
        5:  ins = {6'h23, r1, r2, im};
        6:  ins = {6'h2B, r1, r2, im};
        7:  ins = {6'h04, r1, r2, im};
        8:  ins = {6'h05, r1, r2, im};
        9:  ins = {($urandom_range(0, 1) == 1) ? 6'h03 : 6'h02, 26'($urandom)};
        default: ins = {6'h00, r1, 15'd0, 6'h08};
      endcase
      pc = {$urandom, 2'b00};
      load(pc, ins);
      ex_reg_write = 1'($urandom); ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_write_reg = 5'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom); mem_mem_read = ($urandom_range(0, 3) == 0);
      mem_write_reg = 5'($urandom_range(0, 7)); mem_alu_result = 32'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom_range(0, 7));
      wb_write_data = 32'($urandom_range(0, 3));
      check_all(pc, ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage pipeline, directly downstream of the fetch stage.
- Holds the IF/ID pipeline register, the 32×32 register file and branch/jump resolution.
- Detects hazards and drives the fetch-stage control signals: `stall`, `branch_taken`, `jump_taken`, `branch_offset` and `new_addr`.
- Registers decoded operands into the ID/EX pipeline register for the execute stage.

## Interface
Parameters:
- none; widths come from `WORD` (32) in `constants.v`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_pc`, `if_instruction`  in  32 each  PC and instruction from fetch.
- `wb_reg_write`  in  1  write-back enable. `wb_write_reg`  in  5. `wb_write_data`  in  32.
- `ex_reg_write`, `ex_mem_read`  in  1 each. `ex_write_reg`  in  5  destination of the instruction in EX.
- `mem_reg_write`, `mem_mem_read`  in  1 each. `mem_write_reg`  in  5. `mem_alu_result`  in  32.
- `stall`  out  1  combinational; freezes the PC and IF/ID.
- `branch_taken`, `jump_taken`  out  1 each  combinational.
- `branch_offset`  out  32  sign-extended imm16, in words.
- `new_addr`  out  32  word address for a jump.
- `id_ex_valid`  out  1  registered.
- `id_ex_pc`, `id_ex_rs_data`, `id_ex_rt_data`, `id_ex_imm`  out  32 each  registered.
- `id_ex_opcode`, `id_ex_funct`  out  6 each  registered.
- `id_ex_rs`, `id_ex_rt`, `id_ex_rd`, `id_ex_shamt`  out  5 each  registered.
- `id_ex_link`  out  1  registered; set for `jal`.

## Operation
- **IF/ID register.** Captures `if_pc` and `if_instruction` each cycle unless `stall`.
  - When a flush is pending it loads a bubble: `valid`=0, instruction 0.
- **Flush.** A flush is pending when `branch_taken` or `jump_taken` is 1.
  - The fall-through instruction is squashed; there is no delay slot.
- **Decoded opcodes:**
  - `beq` 000100, `bne` 000101.
  - `j` 000010, `jal` 000011.
  - `jr`: opcode 0, funct 001000.
- **Branch and jump outputs.**
  - `branch_taken` = valid & ~stall & ((beq & a==b) | (bne & a!=b)).
  - `jump_taken` = valid & ~stall & (j | jal | jr).
  - `new_addr` = {6'b0, instr[25:0]} for `j`/`jal`; rs operand >> 2 for `jr`.
- **Branch operands a/b.** Priority order:
  1. Register 0 reads 0.
  2. `mem_alu_result` if `mem_reg_write`, `~mem_mem_read` and `mem_write_reg` matches.
  3. Otherwise the register file, with the same-cycle WB write bypassed (write-first).
- **Stall sources.** Register 0 never matches in any of these checks.
  - Load-use: `ex_mem_read` and `ex_write_reg` equals a used rs/rt.
  - Branch/`jr` operand whose value is not yet available, either of:
    - `ex_reg_write` and `ex_write_reg` matches;
    - `mem_mem_read` and `mem_write_reg` matches.
- **Stall response.** IF/ID holds and ID/EX loads a bubble.
  - Bubble: `id_ex_valid`=0 and every `id_ex_*` field 0.
- **Immediate.** `id_ex_imm` is zero-extended for opcodes 0011xx (andi/ori/xori/lui); sign-extended otherwise.
- **Register file.** Writes on the clock edge when `wb_reg_write` and `wb_write_reg`≠0.
- **Reset.**
  - IF/ID bubble and ID/EX bubble.
  - All 32 registers cleared.
  - `stall`, `branch_taken` and `jump_taken` evaluate to 0.

## Timing
- Decode latency is 1 cycle: an instruction in IF/ID at cycle n is in ID/EX at n+1.
- Control outputs are combinational from IF/ID and the hazard inputs, and are sampled by fetch at the same edge.
- Taken branch/jump:
  - Fetch loads the target at the next edge.
  - IF/ID holds a bubble for exactly one cycle, so the penalty is 1 cycle.
- Load-use: 1 stall cycle.
- Branch after an ALU producer: 1 stall cycle, then forwarded from MEM.
- Branch after a load:
  - 2 stall cycles when the load is in EX.
  - 1 stall cycle when the load is in MEM.
- Stall and flush conditions in the same cycle: stall wins, and a branch is never signalled while stalled.
- WB writing the same register ID is reading in that cycle: ID sees the new value.
- `rst` mid-stall: everything is cleared on that edge; the held instruction is discarded.

## Structure
- `constants.v` gains opcode/funct constants (`OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `FUNCT_JR`) and `REG_ADDR` (5).
- Sub-module `reg_file`:
  - ports `clk`, `rst`, `we`, `waddr`, `wdata`, `raddr1`, `raddr2`, `rdata1`, `rdata2`;
  - reads are combinational with write-first bypass.
- Hazard detection and forwarding select are combinational logic inside `id_stage`.

## Test plan
- Reset, then `addi $1,$0,5` (0x20010005) in IF -> next cycle `id_ex_valid`=1, `id_ex_imm`=5, `id_ex_rt`=1, `stall`=0.
- `lw $2,0($1)` in EX, `add $3,$2,$2` in ID -> `stall`=1 for one cycle, ID/EX bubble; then `add` issues with `id_ex_valid`=1.
- $4=7 in reg file, `beq $4,$4,-3` -> `branch_taken`=1, `branch_offset`=0xFFFFFFFD; next cycle IF/ID is a bubble.
- ALU writing $5=9 in MEM, `bne $5,$0,2` in ID -> forwarded, `branch_taken`=1, `stall`=0.
- `jr $31` with $31=0x40 -> `jump_taken`=1, `new_addr`=0x10.
- WB writes $6=0xAA while ID reads $6 -> `id_ex_rs_data`=0xAA. Then assert `rst` during a stall -> all `id_ex_*`=0 and `stall`=0.
